rob_param: RTL and testbench

// Parametrised reorder buffer: circular queue of in-flight instructions between decoder and

---
 rtl/rob_param.sv | 216 +++++++++++++++++++++
 tb/tb_rob_param.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// rob_param: circular reorder buffer between decode and commit, NUM_CDB result channels.
// Commit outputs are registered one cycle after the head entry becomes ready; lookups are combinational.
// Stores wait at the head until st_ready; rdy low freezes state. Macro ROB_CDB_BYPASS_EN adds CDB->lookup forwarding.
module rob_param #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = 4,
  parameter int XLEN     = 32,
  parameter int NUM_CDB  = 2,
  parameter int BP_IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [1:0]               alloc_kind,
  input  logic [4:0]               alloc_rd,
  input  logic [1:0]               alloc_size,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     alloc_pred,
  input  logic [TAG_W-1:0]         q1_tag,
  input  logic [TAG_W-1:0]         q2_tag,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [XLEN-1:0]          q1_value,
  output logic [XLEN-1:0]          q2_value,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_aux,
  output logic                     cm_valid,
  output logic [4:0]               cm_rd,
  output logic [TAG_W-1:0]         cm_tag,
  output logic [XLEN-1:0]          cm_value,
  output logic                     st_valid,
  input  logic                     st_ready,
  output logic [XLEN-1:0]          st_addr,
  output logic [XLEN-1:0]          st_data,
  output logic [1:0]               st_size,
  output logic                     bp_valid,
  output logic [BP_IDX_W-1:0]      bp_idx,
  output logic                     bp_taken,
  output logic                     flush,
  output logic [XLEN-1:0]          flush_pc,
  output logic [TAG_W:0]           count
);
  localparam logic [1:0] K_REG = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3;

  logic [DEPTH-1:0] busy, done;
  logic [1:0]       e_kind [DEPTH];
  logic [4:0]       e_rd   [DEPTH];
  logic [1:0]       e_size [DEPTH];
  logic [XLEN-1:0]  e_pc   [DEPTH];
  logic             e_pred [DEPTH];
  logic [XLEN-1:0]  e_val  [DEPTH];
  logic [XLEN-1:0]  e_aux  [DEPTH];
  logic [TAG_W-1:0] head, tail, nxt;

  logic [TAG_W-1:0] c_tag [NUM_CDB];
  logic [XLEN-1:0]  c_val [NUM_CDB];
  logic [XLEN-1:0]  c_aux [NUM_CDB];

  for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb
    assign c_tag[g] = cdb_tag[g*TAG_W +: TAG_W];
    assign c_val[g] = cdb_value[g*XLEN +: XLEN];
    assign c_aux[g] = cdb_aux[g*XLEN +: XLEN];
  end

  logic alloc_fire, head_go, next_st, retire;

  assign alloc_ready = (count < (TAG_W+1)'(DEPTH)) && !flush;
  assign alloc_tag   = tail;
  assign alloc_fire  = rdy && alloc_valid && alloc_ready;
  assign head_go     = busy[head] && done[head];
  assign nxt         = head + 1'b1;
  // a second ready store right behind the head keeps st_valid up across the handshake
  assign next_st     = busy[nxt] && done[nxt] && (e_kind[nxt] == K_STORE);
  // nothing commits during the flush cycle; a presented store retires only on its handshake
  assign retire      = rdy && !flush &&
                       (st_valid ? st_ready : (head_go && (e_kind[head] != K_STORE)));

  // busy/done bits: CDB completion, retire clear, alloc set; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
      done <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_CDB; i++)
        if (cdb_valid[i] && busy[c_tag[i]]) done[c_tag[i]] <= 1'b1;
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
      end
    end
  end

  // entry payload; channels walked high to low so the lowest index lands last and wins
  always_ff @(posedge clk) begin
    if (!rst && !flush && rdy) begin
      for (int i = NUM_CDB-1; i >= 0; i--)
        if (cdb_valid[i] && busy[c_tag[i]]) begin
          e_val[c_tag[i]] <= c_val[i];
          e_aux[c_tag[i]] <= c_aux[i];
        end
      if (alloc_fire) begin
        e_kind[tail] <= alloc_kind;
        e_rd[tail]   <= alloc_rd;
        e_size[tail] <= alloc_size;
        e_pc[tail]   <= alloc_pc;
        e_pred[tail] <= alloc_pred;
        e_val[tail]  <= '0;
        e_aux[tail]  <= '0;
      end
    end
  end

  // head/tail pointers and occupancy; the flush pulse resets them on the following edge
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (retire)     head <= head + 1'b1;
      if (alloc_fire) tail <= tail + 1'b1;
      count <= count + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, retire};
    end
  end

  // registered commit side: regfile write, store request, predictor update, redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      cm_valid <= 1'b0; cm_rd <= '0; cm_tag <= '0; cm_value <= '0;
      st_valid <= 1'b0; st_addr <= '0; st_data <= '0; st_size <= '0;
      bp_valid <= 1'b0; bp_idx <= '0; bp_taken <= 1'b0;
      flush    <= 1'b0; flush_pc <= '0;
    end else begin
      cm_valid <= 1'b0;
      bp_valid <= 1'b0;
      flush    <= 1'b0;
      if (rdy && !flush) begin
        if (st_valid) begin
          if (st_ready) begin
            if (next_st) begin
              st_addr <= e_aux[nxt];
              st_data <= e_val[nxt];
              st_size <= e_size[nxt];
            end else begin
              st_valid <= 1'b0;
            end
          end
        end else if (head_go) begin
          case (e_kind[head])
            K_REG, K_JALR: begin
              cm_valid <= 1'b1;
              cm_rd    <= e_rd[head];
              cm_tag   <= head;
              cm_value <= e_val[head];
              if (e_kind[head] == K_JALR) begin
                flush    <= 1'b1;
                flush_pc <= e_aux[head];
              end
            end
            K_BRANCH: begin
              bp_valid <= 1'b1;
              bp_idx   <= e_pc[head][BP_IDX_W+1:2];
              bp_taken <= e_val[head][0];
              if (e_val[head][0] != e_pred[head]) begin
                flush    <= 1'b1;
                flush_pc <= e_val[head][0] ? e_aux[head] : e_pc[head] + XLEN'(4);
              end
            end
            default: begin
              st_valid <= 1'b1;
              st_addr  <= e_aux[head];
              st_data  <= e_val[head];
              st_size  <= e_size[head];
            end
          endcase
        end
      end
    end
  end

  // operand lookup port 1; optional same-cycle CDB forward overrides the entry
  always_comb begin
    q1_ready = busy[q1_tag] && done[q1_tag];
    q1_value = busy[q1_tag] ? e_val[q1_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
    for (int i = NUM_CDB-1; i >= 0; i--)
      if (cdb_valid[i] && (c_tag[i] == q1_tag)) begin
        q1_ready = 1'b1;
        q1_value = c_val[i];
      end
`endif
  end

  // operand lookup port 2; same rules as port 1
  always_comb begin
    q2_ready = busy[q2_tag] && done[q2_tag];
    q2_value = busy[q2_tag] ? e_val[q2_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
    for (int i = NUM_CDB-1; i >= 0; i--)
      if (cdb_valid[i] && (c_tag[i] == q2_tag)) begin
        q2_ready = 1'b1;
        q2_value = c_val[i];
      end
`endif
  end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: directed stimulus for rob_param with a queue-level reference model.
// The model tracks in-flight instructions as an ordered list and predicts every output each cycle.
// Hand-computed literal checks pin commit order, wrap, flush targets, store hold and bypass timing.
module tb_rob_param;
  localparam int DEPTH = 16, TAG_W = 4, XLEN = 32, NC = 2, BPW = 8;

  logic clk = 1'b0;
  logic rst, rdy;
  logic alloc_valid, alloc_ready, alloc_pred;
  logic [TAG_W-1:0] alloc_tag, q1_tag, q2_tag, cm_tag;
  logic [1:0] alloc_kind, alloc_size, st_size;
  logic [4:0] alloc_rd, cm_rd;
  logic [XLEN-1:0] alloc_pc, q1_value, q2_value, cm_value, st_addr, st_data, flush_pc;
  logic q1_ready, q2_ready, cm_valid, st_valid, st_ready, bp_valid, bp_taken, flush;
  logic [NC-1:0] cdb_valid;
  logic [NC*TAG_W-1:0] cdb_tag;
  logic [NC*XLEN-1:0] cdb_value, cdb_aux;
  logic [BPW-1:0] bp_idx;
  logic [TAG_W:0] count;

  always #5 clk = ~clk;

  rob_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .NUM_CDB(NC), .BP_IDX_W(BPW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_size(alloc_size),
    .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_aux(cdb_aux),
    .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .bp_valid(bp_valid), .bp_idx(bp_idx), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  int nvec = 0, nfail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: ordered list of in-flight instructions ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [1:0]       kind;
    logic [4:0]       rd;
    logic [1:0]       size;
    logic [31:0]      pc;
    logic             pred;
    logic             done;
    logic [31:0]      val;
    logic [31:0]      aux;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  logic e_cm, e_bp, e_fl, e_st, e_bpt;
  logic [4:0] e_rd;
  logic [TAG_W-1:0] e_tag;
  logic [31:0] e_cmv, e_flpc, e_sta, e_std;
  logic [1:0] e_sts;
  logic [BPW-1:0] e_bpi;
  logic [31:0] cm_log[$];

  always @(posedge clk) begin
    ent_t h, n;
    bit ret, dup;
    int sz0;
    if (rst) begin
      mq.delete(); m_tail = 0;
      e_cm = 0; e_bp = 0; e_fl = 0; e_st = 0; e_bpt = 0;
      e_rd = 0; e_tag = 0; e_cmv = 0; e_flpc = 0; e_sta = 0; e_std = 0; e_sts = 0; e_bpi = 0;
    end else if (e_fl) begin
      mq.delete(); m_tail = 0;
      e_fl = 0; e_cm = 0; e_bp = 0;
    end else if (!rdy) begin
      e_cm = 0; e_bp = 0;
    end else begin
      sz0 = mq.size();
      ret = 0; e_cm = 0; e_bp = 0;
      if (e_st) begin
        if (st_ready) begin
          ret = 1;
          if (mq.size() > 1 && mq[1].done && mq[1].kind == 2'd1) begin
            e_sta = mq[1].aux; e_std = mq[1].val; e_sts = mq[1].size;
          end else e_st = 0;
        end
      end else if (mq.size() > 0 && mq[0].done) begin
        h = mq[0];
        case (h.kind)
          2'd0, 2'd3: begin
            e_cm = 1; e_rd = h.rd; e_tag = h.tag; e_cmv = h.val; ret = 1;
            if (h.kind == 2'd3) begin e_fl = 1; e_flpc = h.aux; end
          end
          2'd2: begin
            e_bp = 1; e_bpi = h.pc[BPW+1:2]; e_bpt = h.val[0]; ret = 1;
            if (h.val[0] != h.pred) begin
              e_fl = 1;
              e_flpc = h.val[0] ? h.aux : h.pc + 32'd4;
            end
          end
          default: begin
            e_st = 1; e_sta = h.aux; e_std = h.val; e_sts = h.size;
          end
        endcase
      end
      for (int c = 0; c < NC; c++) begin
        if (cdb_valid[c]) begin
          dup = 0;
          for (int d = 0; d < c; d++)
            if (cdb_valid[d] && cdb_tag[d*TAG_W +: TAG_W] == cdb_tag[c*TAG_W +: TAG_W]) dup = 1;
          if (!dup)
            foreach (mq[k])
              if (mq[k].tag == cdb_tag[c*TAG_W +: TAG_W]) begin
                mq[k].done = 1;
                mq[k].val  = cdb_value[c*XLEN +: XLEN];
                mq[k].aux  = cdb_aux[c*XLEN +: XLEN];
              end
        end
      end
      if (ret) void'(mq.pop_front());
      if (alloc_valid && sz0 < DEPTH) begin
        n.tag = TAG_W'(m_tail); n.kind = alloc_kind; n.rd = alloc_rd; n.size = alloc_size;
        n.pc = alloc_pc; n.pred = alloc_pred; n.done = 0; n.val = 0; n.aux = 0;
        mq.push_back(n);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  task automatic look(input logic [TAG_W-1:0] t, output logic r, output logic [31:0] v);
    r = 0; v = 0;
    foreach (mq[k])
      if (mq[k].tag == t) begin
        r = mq[k].done;
        v = mq[k].done ? mq[k].val : 32'd0;
      end
`ifdef ROB_CDB_BYPASS_EN
    for (int c = NC-1; c >= 0; c--)
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
        r = 1; v = cdb_value[c*XLEN +: XLEN];
      end
`endif
  endtask

  // compare process: every output against the model, mid-cycle
  always @(negedge clk) begin
    logic lr;
    logic [31:0] lv;
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH && !e_fl));
    chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    chk("count", 32'(count), 32'(mq.size()));
    chk("cm_valid", 32'(cm_valid), 32'(e_cm));
    chk("cm_rd", 32'(cm_rd), 32'(e_rd));
    chk("cm_tag", 32'(cm_tag), 32'(e_tag));
    chk("cm_value", cm_value, e_cmv);
    chk("bp_valid", 32'(bp_valid), 32'(e_bp));
    chk("bp_idx", 32'(bp_idx), 32'(e_bpi));
    chk("bp_taken", 32'(bp_taken), 32'(e_bpt));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("flush_pc", flush_pc, e_flpc);
    chk("st_valid", 32'(st_valid), 32'(e_st));
    chk("st_addr", st_addr, e_sta);
    chk("st_data", st_data, e_std);
    chk("st_size", 32'(st_size), 32'(e_sts));
    look(q1_tag, lr, lv);
    chk("q1_ready", 32'(q1_ready), 32'(lr));
    chk("q1_value", q1_value, lv);
    look(q2_tag, lr, lv);
    chk("q2_ready", 32'(q2_ready), 32'(lr));
    chk("q2_value", q2_value, lv);
    if (cm_valid) cm_log.push_back(cm_value);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
    alloc_valid = 0;
    cdb_valid = '0;
  endtask

  task automatic alloc(input logic [1:0] k, input logic [4:0] r, input logic [31:0] pc,
                       input logic pr, input logic [1:0] sz);
    alloc_valid = 1; alloc_kind = k; alloc_rd = r; alloc_pc = pc; alloc_pred = pr; alloc_size = sz;
    tick();
  endtask

  task automatic bcast(input int ch, input logic [TAG_W-1:0] t, input logic [31:0] v, input logic [31:0] a);
    cdb_valid[ch] = 1;
    cdb_tag[ch*TAG_W +: TAG_W] = t;
    cdb_value[ch*XLEN +: XLEN] = v;
    cdb_aux[ch*XLEN +: XLEN] = a;
  endtask

  task automatic wait_flush();
    for (int i = 0; i < 20 && !flush; i++) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && count != 0; i++) tick();
    chk("drain_count", 32'(count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; rdy = 1; alloc_valid = 0; alloc_kind = 0; alloc_rd = 0; alloc_size = 0;
    alloc_pc = 0; alloc_pred = 0; q1_tag = 0; q2_tag = 0; cdb_valid = '0; cdb_tag = '0;
    cdb_value = '0; cdb_aux = '0; st_ready = 1;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_cm_valid", 32'(cm_valid), 0);
    rst = 0;
    tick();

    // out-of-order completion, in-order commit
    cm_log.delete();
    alloc(2'd0, 5'd1, 32'h10, 0, 0);
    alloc(2'd0, 5'd2, 32'h14, 0, 0);
    alloc(2'd0, 5'd3, 32'h18, 0, 0);
    bcast(0, 4'd2, 32'h22, 0); tick();
    bcast(0, 4'd0, 32'h11, 0); tick();
    bcast(0, 4'd1, 32'h33, 0); tick();
    for (int i = 0; i < 6; i++) tick();
    chk("order_n", 32'(cm_log.size()), 3);
    chk("order_0", cm_log[0], 32'h11);
    chk("order_1", cm_log[1], 32'h33);
    chk("order_2", cm_log[2], 32'h22);

    // fill to DEPTH; tail runs 3..15 then wraps to 0
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 12) chk("tag_15", 32'(alloc_tag), 15);
      if (i == 13) chk("tag_wrap", 32'(alloc_tag), 0);
      alloc(2'd0, 5'(i), 32'h1000 + 32'(4*i), 0, 0);
    end
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(alloc_ready), 0);
    alloc(2'd0, 5'd31, 32'hBAD0, 0, 0);
    chk("full_ignored", 32'(count), 16);
    bcast(0, 4'd3, 32'h300, 0); tick();
    chk("full_pre_retire", 32'(count), 16);
    tick();
    chk("retire_count", 32'(count), 15);
    chk("retire_ready", 32'(alloc_ready), 1);
    for (int t = 4; t < 19; t += 2) begin
      bcast(0, 4'(t), 32'(t), 0);
      if (t + 1 < 19) bcast(1, 4'(t + 1), 32'(t + 1), 0);
      tick();
    end
    drain();

    // correctly predicted taken branch: predictor update only
    alloc(2'd2, 5'd0, 32'h80, 1, 0);
    bcast(0, 4'd3, 32'd1, 32'h200); tick();
    for (int i = 0; i < 10 && !bp_valid; i++) tick();
    chk("bp_ok_valid", 32'(bp_valid), 1);
    chk("bp_ok_idx", 32'(bp_idx), 32'h20);
    chk("bp_ok_noflush", 32'(flush), 0);
    tick();

    // mispredicted not-predicted-taken branch with a younger instruction behind it
    alloc(2'd0, 5'd7, 32'h3C, 0, 0);
    alloc(2'd2, 5'd0, 32'h40, 0, 0);
    alloc(2'd0, 5'd8, 32'h44, 0, 0);
    bcast(0, 4'd4, 32'h77, 0); bcast(1, 4'd5, 32'd1, 32'h100); tick();
    wait_flush();
    chk("br_flush", 32'(flush), 1);
    chk("br_flush_pc", flush_pc, 32'h100);
    chk("br_taken", 32'(bp_taken), 1);
    chk("br_idx", 32'(bp_idx), 32'h10);
    tick();
    chk("br_count_after", 32'(count), 0);
    chk("br_tail_after", 32'(alloc_tag), 0);

    // both channels hit tag 5; then same-cycle lookup of tag 4
    for (int i = 0; i < 6; i++) alloc(2'd0, 5'(10 + i), 32'h2000 + 32'(4*i), 0, 0);
    q2_tag = 4'd5;
    bcast(0, 4'd5, 32'hA, 0); bcast(1, 4'd5, 32'hB, 0); tick();
    q1_tag = 4'd5; #1;
    chk("dual_cdb_ready", 32'(q1_ready), 1);
    chk("dual_cdb_value", q1_value, 32'hA);
    q1_tag = 4'd4;
    bcast(0, 4'd4, 32'h44, 0); #2;
`ifdef ROB_CDB_BYPASS_EN
    chk("bypass_ready", 32'(q1_ready), 1);
    chk("bypass_value", q1_value, 32'h44);
`else
    chk("nobypass_ready", 32'(q1_ready), 0);
`endif
    tick();
    chk("late_ready", 32'(q1_ready), 1);
    chk("late_value", q1_value, 32'h44);
    bcast(0, 4'd0, 32'h100, 0); bcast(1, 4'd1, 32'h101, 0); tick();
    bcast(0, 4'd2, 32'h102, 0); bcast(1, 4'd3, 32'h103, 0); tick();
    drain();

    // store held under backpressure, then back-to-back stores
    st_ready = 0;
    alloc(2'd1, 5'd0, 32'h600, 0, 2'd2);
    bcast(0, 4'd6, 32'hDEAD, 32'h1000); tick();
    for (int i = 0; i < 4; i++) tick();
    chk("st_held_valid", 32'(st_valid), 1);
    chk("st_held_addr", st_addr, 32'h1000);
    chk("st_held_data", st_data, 32'hDEAD);
    chk("st_held_count", 32'(count), 1);
    st_ready = 1; tick();
    chk("st_done_valid", 32'(st_valid), 0);
    chk("st_done_count", 32'(count), 0);
    alloc(2'd1, 5'd0, 32'h604, 0, 2'd0);
    alloc(2'd1, 5'd0, 32'h608, 0, 2'd1);
    bcast(0, 4'd7, 32'h5A, 32'h2001); bcast(1, 4'd8, 32'hBEEF, 32'h2002); tick();
    for (int i = 0; i < 6; i++) tick();
    chk("st_b2b_count", 32'(count), 0);

    // predicted-taken branch that falls through: redirect to pc+4
    alloc(2'd2, 5'd0, 32'h300, 1, 0);
    bcast(1, 4'd9, 32'd0, 32'h999); tick();
    wait_flush();
    chk("nt_flush", 32'(flush), 1);
    chk("nt_flush_pc", flush_pc, 32'h304);
    tick();

    // JALR: regfile commit plus redirect
    alloc(2'd3, 5'd5, 32'h500, 0, 0);
    bcast(0, 4'd0, 32'h55, 32'h400); tick();
    wait_flush();
    chk("jalr_flush", 32'(flush), 1);
    chk("jalr_cm_valid", 32'(cm_valid), 1);
    chk("jalr_cm_value", cm_value, 32'h55);
    chk("jalr_flush_pc", flush_pc, 32'h400);
    tick();

    // freeze: allocs and broadcasts ignored while rdy is low
    alloc(2'd0, 5'd9, 32'h700, 0, 0);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; bcast(0, 4'd0, 32'h77, 0); tick();
    end
    chk("frz_count", 32'(count), 1);
    chk("frz_tag", 32'(alloc_tag), 1);
    chk("frz_cm", 32'(cm_valid), 0);
    rdy = 1;
    bcast(0, 4'd0, 32'h99, 0); tick();
    tick();
    chk("frz_cm_valid", 32'(cm_valid), 1);
    chk("frz_cm_value", cm_value, 32'h99);

    // reset in the middle of activity
    alloc(2'd0, 5'd1, 32'h800, 0, 0);
    alloc(2'd0, 5'd2, 32'h804, 0, 0);
    rst = 1; tick();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_tag", 32'(alloc_tag), 0);
    rst = 0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
